// File: rtl/var_bw_pkg.sv
// Shared definitions for the variable-bit-width arithmetic blocks: FSM state
// encoding, default operand width and the active-width clamp.
package var_bw_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A requested width of 0, or one wider than the datapath, means "full width".
    function automatic int unsigned clamp_bw(input int unsigned bw, input int unsigned width);
        return ((bw == 0) || (bw > width)) ? width : bw;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared bit-serially by the add sequencer.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full_adder cell reused for bits 0..n-1, one bit per clock.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output out_ovf.
module serial_add_seq
    import var_bw_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int BW_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic [BW_W-1:0]  in_bw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sum_r;
    logic [BW_W-1:0]  n_r;
    logic [BW_W-1:0]  idx;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             last;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_r;
`endif

    // Operands are shifted right so the active bit is always at position 0;
    // the one-hot mask marks where the produced sum bit lands.
    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last      = (idx == (n_r - BW_W'(1)));
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_sum   = sum_r;
    assign out_co    = carry;
`ifdef SERIAL_ADD_OVF_EN
    assign out_ovf   = ovf_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            carry <= 1'b0;
            sum_r <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        n_r   <= BW_W'(clamp_bw(32'(in_bw), WIDTH));
                        carry <= in_ci;
                        idx   <= '0;
                        mask  <= WIDTH'(1);
                        sum_r <= '0;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_r <= 1'b0;
`endif
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fa_s) begin
                        sum_r <= sum_r | mask;
                    end
                    carry <= fa_co;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    mask  <= mask << 1;
                    // idx stops at n-1: the FSM leaves RUN instead of wrapping.
                    if (last) begin
`ifdef SERIAL_ADD_OVF_EN
                        ovf_r <= carry ^ fa_co;
`endif
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + BW_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq (WIDTH=16).
// Build with SERIAL_ADD_OVF_EN defined to also exercise out_ovf.
module tb_serial_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_ci = 1'b0;
    logic [4:0]  in_bw = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_co;
`ifdef SERIAL_ADD_OVF_EN
    logic        out_ovf;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_bw     (in_bw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    typedef struct {
        logic [4:0]  bw;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] sum;
        logic        co;
        int          lat;
    } vec_t;

    // Issues one request from IDLE, waits (bounded) for the result and then
    // completes the handshake with out_ready held high. Latency counts cycles
    // from the accept cycle to the first cycle with out_valid high.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic [4:0] bw, output int lat,
                          output logic [15:0] sum, output logic co);
        in_a = a; in_b = b; in_ci = ci; in_bw = bw;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        sum = out_sum;
        co  = out_co;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_sum !== 16'h0000) $display("FAIL reset_out_sum: got %h expected 0000", out_sum);
        else pass_cnt++;
        total_cnt++;
        if (out_co !== 1'b0) $display("FAIL reset_out_co: got %b expected 0", out_co);
        else pass_cnt++;
    endtask

    task automatic test_add_vectors();
        vec_t        v [6];
        int          lat;
        logic [15:0] sum;
        logic        co;
        v = '{
            '{5'd8,  16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 9},
            '{5'd0,  16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 17},
            '{5'd4,  16'hFFF7, 16'hFFF8, 1'b0, 16'h000F, 1'b0, 5},
            '{5'd1,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 2},
            '{5'd17, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 17},
            '{5'd12, 16'h0ABC, 16'h0123, 1'b0, 16'h0BDF, 1'b0, 13}
        };
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, v[i].ci, v[i].bw, lat, sum, co);
            total_cnt++;
            if (sum !== v[i].sum) $display("FAIL add%0d_sum: got %h expected %h", i, sum, v[i].sum);
            else pass_cnt++;
            total_cnt++;
            if (co !== v[i].co) $display("FAIL add%0d_co: got %b expected %b", i, co, v[i].co);
            else pass_cnt++;
            total_cnt++;
            if (lat !== v[i].lat) $display("FAIL add%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        in_a = 16'h0012; in_b = 16'h0034; in_ci = 1'b0; in_bw = 5'd8;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Second request held while busy: must not be picked up early.
        in_a = 16'h0003; in_b = 16'h0004; in_bw = 5'd4;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (lat !== 9) $display("FAIL bp_latency: got %0d expected 9", lat);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h0046 || out_co !== 1'b0)
                $display("FAIL bp_hold%0d: got valid=%b ready=%b sum=%h co=%b expected valid=1 ready=0 sum=0046 co=0",
                         c, out_valid, in_ready, out_sum, out_co);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_after_handshake: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_second_accept: got in_ready=%b expected 0", in_ready);
        else pass_cnt++;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (out_sum !== 16'h0007 || lat !== 5)
            $display("FAIL bp_second_result: got sum=%h lat=%0d expected sum=0007 lat=5", out_sum, lat);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int t0 = -1;
        int t1 = -1;
        int guard;
        in_a = 16'h0001; in_b = 16'h0001; in_ci = 1'b0; in_bw = 5'd2;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (in_ready) begin
                if (t0 < 0) t0 = c;
                else if (t1 < 0) t1 = c;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (t1 - t0 !== 4) $display("FAIL b2b_interval: got %0d expected 4", t1 - t0);
        else pass_cnt++;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic test_reset_mid_run();
        int          lat;
        logic [15:0] sum;
        logic        co;
        int          seen;
        in_a = 16'h00FF; in_b = 16'h0001; in_ci = 1'b0; in_bw = 5'd8;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0000)
            $display("FAIL midrst_state: got ready=%b valid=%b sum=%h expected ready=1 valid=0 sum=0000",
                     in_ready, out_valid, out_sum);
        else pass_cnt++;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL midrst_no_result: got %0d valid cycles expected 0", seen);
        else pass_cnt++;
        run_op(16'h0005, 16'h0003, 1'b0, 5'd4, lat, sum, co);
        total_cnt++;
        if (sum !== 16'h0008 || co !== 1'b0 || lat !== 5)
            $display("FAIL midrst_fresh: got sum=%h co=%b lat=%0d expected sum=0008 co=0 lat=5", sum, co, lat);
        else pass_cnt++;
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        int          lat;
        logic [15:0] sum;
        logic        co;
        logic        ovf;
        in_a = 16'h007F; in_b = 16'h0001; in_ci = 1'b0; in_bw = 5'd8;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        sum = out_sum; co = out_co; ovf = out_ovf;
        @(posedge clk); #1;
        total_cnt++;
        if (sum !== 16'h0080 || co !== 1'b0 || ovf !== 1'b1)
            $display("FAIL ovf_pos: got sum=%h co=%b ovf=%b expected sum=0080 co=0 ovf=1", sum, co, ovf);
        else pass_cnt++;
        in_a = 16'h00FF; in_b = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        sum = out_sum; co = out_co; ovf = out_ovf;
        @(posedge clk); #1;
        total_cnt++;
        if (sum !== 16'h0000 || co !== 1'b1 || ovf !== 1'b0)
            $display("FAIL ovf_wrap: got sum=%h co=%b ovf=%b expected sum=0000 co=1 ovf=0", sum, co, ovf);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_add_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
